// File: rtl/cclut_pkg.sv
// cclut_pkg: widths, opcodes and LUT data fields shared by the CCLUT loader and pattern-LUT decoder
package cclut_pkg;
   localparam int MXADRB = 11;
   localparam int MXDATB = 9;
   localparam int MXPID  = 5;
   localparam int MXCKSB = 16;
   localparam logic [2:0] PID_ALL = 3'd7;
   localparam int BEND_LSB = 0;
   localparam int BEND_W   = 5;
   localparam int OFFS_LSB = 5;
   localparam int OFFS_W   = 4;
   typedef enum logic [1:0] {OP_SETPTR = 2'd0, OP_WRITE = 2'd1, OP_READ = 2'd2, OP_FILL = 2'd3} op_t;
   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_RD_ADR, S_RD_WAIT, S_RESP, S_FILL} state_t;
   function automatic logic pid_err(input logic [1:0] op, input logic [2:0] pid);
      return (pid == 3'd5) || (pid == 3'd6) || (pid == PID_ALL && op != OP_FILL);
   endfunction
   function automatic logic [BEND_W-1:0] lut_bend(input logic [MXDATB-1:0] d);
      return d[BEND_LSB +: BEND_W];
   endfunction
   function automatic logic [OFFS_W-1:0] lut_offs(input logic [MXDATB-1:0] d);
      return d[OFFS_LSB +: OFFS_W];
   endfunction
endpackage

// File: rtl/cclut_fill_ctr.sv
// cclut_fill_ctr: table address sweep counter; done flags the final address of the table
module cclut_fill_ctr
   import cclut_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              clr,
   input  logic              en,
   output logic [MXADRB-1:0] cnt,
   output logic              done
);
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en) cnt <= cnt + 1'b1;
   assign done = &cnt;
endmodule

// File: rtl/cclut_ram_loader.sv
// cclut_ram_loader: host-side writer for the five pattern LUT RAMs
// pointer set, auto-increment write/readback, bulk fill, running checksum and lut_ready gate
module cclut_ram_loader
   import cclut_pkg::*;
(
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [1:0]              cmd_op,
   input  logic [2:0]              cmd_pid,
   input  logic [MXADRB-1:0]       cmd_adr,
   input  logic [MXDATB-1:0]       cmd_data,
   output logic                    rsp_valid,
   output logic [MXDATB-1:0]       rsp_data,
   output logic                    rsp_err,
   output logic [MXPID-1:0]        ram_we,
   output logic [MXADRB-1:0]       ram_adr,
   output logic [MXDATB-1:0]       ram_wdata,
   input  logic [MXPID*MXDATB-1:0] ram_rdata,
   output logic [MXCKSB-1:0]       checksum,
   output logic                    lut_ready
);
   state_t state, state_nx;
   logic [2:0] pid_reg;
   logic [MXADRB-1:0] pointer, fill_adr;
   logic [MXDATB-1:0] data_reg, rd_reg;
   logic [MXCKSB-1:0] sum;
   logic [MXPID-1:0] pid_mask;
   logic err_reg, wr_d, fill_done, take, cmd_bad, writing;
   assign take = cmd_valid && cmd_ready;
   assign cmd_bad = pid_err(cmd_op, cmd_pid);
   assign writing = state == S_WRITE || state == S_FILL;
   cclut_fill_ctr u_fill_ctr (
      .clock   (clock),
      .reset_n (reset_n),
      .clr     (take),
      .en      (state == S_FILL),
      .cnt     (fill_adr),
      .done    (fill_done)
   );
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) state <= S_IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:    if (cmd_valid) state_nx = cmd_bad ? S_RESP :
                                              cmd_op == OP_WRITE ? S_WRITE :
                                              cmd_op == OP_READ  ? S_RD_ADR :
                                              cmd_op == OP_FILL  ? S_FILL : S_RESP;
         S_WRITE:   state_nx = S_RESP;
         S_RD_ADR:  state_nx = S_RD_WAIT;
         S_RD_WAIT: state_nx = S_RESP;
         S_FILL:    if (fill_done) state_nx = S_RESP;
         default:   state_nx = S_IDLE;
      endcase
   end
   // errored commands leave pid_reg, pointer and checksum untouched
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         pid_reg  <= '0;
         pointer  <= '0;
         sum      <= '0;
         data_reg <= '0;
         rd_reg   <= '0;
         err_reg  <= 1'b0;
         wr_d     <= 1'b0;
      end else begin
         wr_d <= writing;
         if (take) begin
            data_reg <= cmd_data;
            rd_reg   <= '0;
            err_reg  <= cmd_bad;
            if (!cmd_bad) pid_reg <= cmd_pid;
            if (!cmd_bad && cmd_op == OP_SETPTR) begin
               pointer <= cmd_adr;
               sum     <= '0;
            end
         end
         if (state == S_WRITE) begin
            sum     <= sum + MXCKSB'(data_reg);
            pointer <= pointer + 1'b1;
         end
         if (state == S_RD_WAIT) begin
            rd_reg  <= ram_rdata[int'(pid_reg)*MXDATB +: MXDATB];
            pointer <= pointer + 1'b1;
         end
      end
   always_comb begin
      pid_mask  = pid_reg == PID_ALL ? {MXPID{1'b1}} : MXPID'(1) << pid_reg;
      cmd_ready = state == S_IDLE;
      rsp_valid = state == S_RESP;
      rsp_err   = rsp_valid && err_reg;
      rsp_data  = rsp_valid ? rd_reg : '0;
      ram_we    = writing ? pid_mask : '0;
      ram_wdata = writing ? data_reg : '0;
      ram_adr   = state == S_FILL ? fill_adr :
                  (state == S_WRITE || state == S_RD_ADR || state == S_RD_WAIT) ? pointer : '0;
      lut_ready = !(writing || wr_d);
      checksum  = sum;
   end
endmodule

// File: tb/tb_cclut_ram_loader.sv
// tb_cclut_ram_loader: randomized checks of the LUT loader against a table-level reference model
module tb_cclut_ram_loader;
   logic clock = 0, reset_n = 0, cmd_valid = 0;
   logic [1:0] cmd_op = 0;
   logic [2:0] cmd_pid = 0;
   logic [10:0] cmd_adr = 0;
   logic [8:0] cmd_data = 0;
   logic cmd_ready, rsp_valid, rsp_err, lut_ready;
   logic [8:0] rsp_data, ram_wdata;
   logic [4:0] ram_we;
   logic [10:0] ram_adr;
   logic [44:0] ram_rdata;
   logic [15:0] checksum;
   logic [8:0] mem [5][2048];
   int ref_mem [5][2048];
   int ref_ptr, ref_sum, nchk, nerr, n_rsp, lr_high;
   logic [10:0] wq_adr[$];
   logic [4:0] wq_we[$];
   logic [8:0] wq_dat[$];
   logic r_err, lr_rsp, ready_after;
   logic [8:0] r_data;
   cclut_ram_loader dut (
      .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_pid(cmd_pid), .cmd_adr(cmd_adr), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .ram_we(ram_we),
      .ram_adr(ram_adr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .checksum(checksum), .lut_ready(lut_ready)
   );
   always #5 clock = ~clock;
   always @(posedge clock) begin
      for (int k = 0; k < 5; k++) begin
         if (ram_we[k]) mem[k][ram_adr] <= ram_wdata;
         ram_rdata[k*9 +: 9] <= mem[k][ram_adr];
      end
   end
   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
      $fatal(1);
   end
   task automatic run_cmd(input logic [1:0] op, input logic [2:0] pid, input logic [10:0] adr, input logic [8:0] dat);
      int n;
      wq_adr.delete(); wq_we.delete(); wq_dat.delete();
      n_rsp = 0; lr_high = 0; r_err = 0; r_data = 0; lr_rsp = 1;
      @(negedge clock);
      cmd_valid = 1; cmd_op = op; cmd_pid = pid; cmd_adr = adr; cmd_data = dat;
      n = 0;
      while (!cmd_ready && n < 10) begin @(negedge clock); n++; end
      @(posedge clock);
      #1;
      cmd_valid = 0; cmd_op = 2'($urandom); cmd_pid = 3'($urandom); cmd_adr = 11'($urandom); cmd_data = 9'($urandom);
      n = 0;
      while (n_rsp == 0 && n < 3000) begin
         @(negedge clock);
         n++;
         if (ram_we != 0) begin
            wq_adr.push_back(ram_adr); wq_we.push_back(ram_we); wq_dat.push_back(ram_wdata);
            if (lut_ready) lr_high++;
         end
         if (rsp_valid) begin n_rsp++; r_err = rsp_err; r_data = rsp_data; lr_rsp = lut_ready; end
      end
      @(negedge clock);
      if (rsp_valid) n_rsp++;
      ready_after = cmd_ready;
   endtask
   task automatic test_reset;
      reset_n = 0; cmd_valid = 1; cmd_op = 1; cmd_pid = 2; cmd_data = 9'h1FF;
      repeat (3) @(negedge clock);
      nchk++; if (cmd_ready !== 1'b1) begin nerr++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
      nchk++; if (ram_we !== 5'b0) begin nerr++; $display("FAIL reset_ram_we: got %b expected 00000", ram_we); end
      nchk++; if (checksum !== 16'h0) begin nerr++; $display("FAIL reset_checksum: got %h expected 0000", checksum); end
      nchk++; if (lut_ready !== 1'b1) begin nerr++; $display("FAIL reset_lut_ready: got %b expected 1", lut_ready); end
      nchk++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
      nchk++; if (ram_adr !== 11'h0) begin nerr++; $display("FAIL reset_ram_adr: got %h expected 000", ram_adr); end
      cmd_valid = 0;
      @(negedge clock);
      reset_n = 1;
      ref_ptr = 0; ref_sum = 0;
   endtask
   task automatic do_setptr(input logic [2:0] pid, input logic [10:0] adr);
      run_cmd(2'd0, pid, adr, 9'($urandom));
      nchk++; if (n_rsp !== 1 || r_err !== 1'b0) begin nerr++; $display("FAIL setptr_rsp: got rsp=%0d err=%b expected rsp=1 err=0", n_rsp, r_err); end
      ref_ptr = adr; ref_sum = 0;
   endtask
   task automatic do_write(input logic [2:0] pid, input logic [8:0] dat);
      run_cmd(2'd1, pid, 11'($urandom), dat);
      nchk++;
      if (wq_adr.size() !== 1 || wq_we[0] !== 5'(1 << pid) || wq_adr[0] !== 11'(ref_ptr) || wq_dat[0] !== dat) begin
         nerr++;
         $display("FAIL write_port: got n=%0d we=%b adr=%h dat=%h expected n=1 we=%b adr=%h dat=%h",
                  wq_adr.size(), wq_we.size() ? wq_we[0] : 5'h0, wq_adr.size() ? wq_adr[0] : 11'h0,
                  wq_dat.size() ? wq_dat[0] : 9'h0, 5'(1 << pid), 11'(ref_ptr), dat);
      end
      ref_mem[pid][ref_ptr] = dat;
      ref_ptr = (ref_ptr + 1) % 2048;
      ref_sum = (ref_sum + dat) % 65536;
      nchk++; if (n_rsp !== 1 || r_err !== 1'b0 || lr_rsp !== 1'b0 || lr_high !== 0) begin
         nerr++; $display("FAIL write_rsp: got rsp=%0d err=%b lut_rsp=%b lut_hi=%0d expected 1 0 0 0", n_rsp, r_err, lr_rsp, lr_high);
      end
      nchk++; if (checksum !== 16'(ref_sum)) begin nerr++; $display("FAIL write_checksum: got %h expected %h", checksum, 16'(ref_sum)); end
   endtask
   task automatic do_read(input logic [2:0] pid);
      run_cmd(2'd2, pid, 11'($urandom), 9'($urandom));
      nchk++; if (n_rsp !== 1 || r_err !== 1'b0 || r_data !== 9'(ref_mem[pid][ref_ptr]) || wq_adr.size() !== 0) begin
         nerr++; $display("FAIL read_data: got rsp=%0d err=%b data=%h writes=%0d expected rsp=1 err=0 data=%h writes=0",
                          n_rsp, r_err, r_data, wq_adr.size(), 9'(ref_mem[pid][ref_ptr]));
      end
      ref_ptr = (ref_ptr + 1) % 2048;
   endtask
   task automatic do_bad(input logic [1:0] op, input logic [2:0] pid);
      run_cmd(op, pid, 11'($urandom), 9'($urandom));
      nchk++; if (n_rsp !== 1 || r_err !== 1'b1 || wq_adr.size() !== 0 || checksum !== 16'(ref_sum) || r_data !== 9'h0) begin
         nerr++; $display("FAIL bad_cmd op%0d pid%0d: got rsp=%0d err=%b writes=%0d cks=%h data=%h expected rsp=1 err=1 writes=0 cks=%h data=000",
                          op, pid, n_rsp, r_err, wq_adr.size(), checksum, r_data, 16'(ref_sum));
      end
   endtask
   task automatic test_write_wrap;
      do_setptr(3'd2, 11'h7FE);
      do_write(3'd2, 9'h155);
      do_write(3'd2, 9'h0AA);
      do_write(3'd2, 9'h001);
      nchk++; if (checksum !== 16'h0200) begin nerr++; $display("FAIL wrap_checksum: got %h expected 0200", checksum); end
      nchk++; if (ready_after !== 1'b1 || lut_ready !== 1'b1) begin nerr++; $display("FAIL idle_after_write: got ready=%b lut=%b expected 1 1", ready_after, lut_ready); end
   endtask
   task automatic test_readback;
      do_setptr(3'd2, 11'h7FE);
      repeat (3) do_read(3'd2);
   endtask
   task automatic test_fill;
      int bad;
      logic [8:0] d;
      d = 9'h0E7;
      run_cmd(2'd3, 3'd7, 11'($urandom), d);
      bad = 0;
      foreach (wq_adr[i]) if (wq_we[i] !== 5'h1F || wq_adr[i] !== 11'(i) || wq_dat[i] !== d) bad++;
      nchk++; if (wq_adr.size() !== 2048 || bad !== 0) begin nerr++; $display("FAIL fill_all_seq: got cycles=%0d bad=%0d expected cycles=2048 bad=0", wq_adr.size(), bad); end
      nchk++; if (lr_high !== 0 || lr_rsp !== 1'b0) begin nerr++; $display("FAIL fill_lut_ready: got high=%0d rsp_lut=%b expected 0 0", lr_high, lr_rsp); end
      nchk++; if (n_rsp !== 1 || r_err !== 1'b0) begin nerr++; $display("FAIL fill_rsp: got rsp=%0d err=%b expected 1 0", n_rsp, r_err); end
      nchk++; if (checksum !== 16'(ref_sum)) begin nerr++; $display("FAIL fill_checksum: got %h expected %h", checksum, 16'(ref_sum)); end
      for (int k = 0; k < 5; k++) for (int a = 0; a < 2048; a++) ref_mem[k][a] = d;
      do_read(3'd4);
      d = 9'($urandom);
      run_cmd(2'd3, 3'd3, 11'($urandom), d);
      bad = 0;
      foreach (wq_adr[i]) if (wq_we[i] !== 5'b01000 || wq_adr[i] !== 11'(i) || wq_dat[i] !== d) bad++;
      nchk++; if (wq_adr.size() !== 2048 || bad !== 0) begin nerr++; $display("FAIL fill_one_seq: got cycles=%0d bad=%0d expected cycles=2048 bad=0", wq_adr.size(), bad); end
      for (int a = 0; a < 2048; a++) ref_mem[3][a] = d;
      do_read(3'd3);
   endtask
   task automatic test_errors;
      do_bad(2'd1, 3'd6);
      do_bad(2'd3, 3'd5);
      do_bad(2'd2, 3'd7);
      do_bad(2'd1, 3'd7);
      do_bad(2'd0, 3'd5);
      do_read(3'd2);
   endtask
   task automatic test_random;
      for (int i = 0; i < 120; i++) begin
         int r;
         logic [2:0] p;
         r = $urandom_range(0, 9);
         p = 3'($urandom_range(0, 4));
         if (r == 0) do_setptr(p, 11'($urandom));
         else if (r < 5) do_write(p, 9'($urandom));
         else if (r < 9) do_read(p);
         else do_bad(2'($urandom_range(0, 2)), 3'($urandom_range(5, 7)));
      end
   endtask
   task automatic test_reset_mid_fill;
      int n;
      logic [8:0] d;
      do_setptr(3'd1, 11'h200);
      d = 9'(ref_mem[1][11'h100] ^ 9'h1FF);
      @(negedge clock);
      cmd_valid = 1; cmd_op = 2'd3; cmd_pid = 3'd1; cmd_data = d;
      @(posedge clock);
      #1 cmd_valid = 0;
      n = 0;
      while (!(ram_we != 0 && ram_adr == 11'h100) && n < 3000) begin @(negedge clock); n++; end
      nchk++; if (ram_adr !== 11'h100) begin nerr++; $display("FAIL midfill_reach: got adr=%h expected 100", ram_adr); end
      reset_n = 0;
      #1;
      nchk++; if (ram_we !== 5'b0 || lut_ready !== 1'b1 || cmd_ready !== 1'b1 || ram_adr !== 11'h0) begin
         nerr++; $display("FAIL midfill_abort: got we=%b lut=%b ready=%b adr=%h expected 00000 1 1 000", ram_we, lut_ready, cmd_ready, ram_adr);
      end
      @(negedge clock);
      reset_n = 1;
      for (int a = 0; a < 11'h100; a++) ref_mem[1][a] = d;
      ref_ptr = 0; ref_sum = 0;
      nchk++; if (checksum !== 16'h0) begin nerr++; $display("FAIL midfill_checksum: got %h expected 0000", checksum); end
      do_read(3'd1);
      do_setptr(3'd1, 11'h0FF);
      do_read(3'd1);
      do_read(3'd1);
   endtask
   initial begin
      nchk = 0; nerr = 0;
      test_reset();
      test_write_wrap();
      test_readback();
      test_fill();
      test_errors();
      test_random();
      test_reset_mid_fill();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
      $finish;
   end
endmodule
